// File: rtl/acc_proc_pkg.sv
// Shared opcode and state encodings for the parametrised accumulator processor.
package acc_proc_pkg;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned STATE_W = 3;

    localparam logic [OPC_W-1:0] OP_LDA  = 4'h0;
    localparam logic [OPC_W-1:0] OP_STA  = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h3;
    localparam logic [OPC_W-1:0] OP_IN   = 4'h4;
    localparam logic [OPC_W-1:0] OP_OUT  = 4'h5;
    localparam logic [OPC_W-1:0] OP_JZ   = 4'h6;
    localparam logic [OPC_W-1:0] OP_JPOS = 4'h7;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'h8;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h9;
    localparam logic [OPC_W-1:0] OP_OR   = 4'hA;
    localparam logic [OPC_W-1:0] OP_SHL  = 4'hB;
    localparam logic [OPC_W-1:0] OP_SHR  = 4'hC;
    localparam logic [OPC_W-1:0] OP_JC   = 4'hD;
    localparam logic [OPC_W-1:0] OP_NOP  = 4'hE;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_IN_WAIT = 3'd3,
        S_HALT    = 3'd4
    } state_t;

endpackage

// File: rtl/acc_proc_alu.sv
// Combinational accumulator/carry update for load, arithmetic, logic and shift ops.
module acc_proc_alu
    import acc_proc_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [OPC_W-1:0]  op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] m,
    input  logic              c,
    output logic [DATA_W-1:0] a_next,
    output logic              c_next
);

    // Ops not handled here leave A and C untouched.
    always_comb begin
        a_next = a;
        c_next = c;
        case (op)
            OP_LDA: a_next = m;
            OP_ADD: {c_next, a_next} = {1'b0, a} + {1'b0, m};
            OP_SUB: {c_next, a_next} = {1'b0, a} - {1'b0, m};
            OP_AND: a_next = a & m;
            OP_OR:  a_next = a | m;
            OP_SHL: {c_next, a_next} = {a, 1'b0};
            OP_SHR: {a_next, c_next} = {1'b0, a};
            default: ;
        endcase
    end

endmodule

// File: rtl/acc_processor_p.sv
// Parametrised accumulator processor: PC, IR, A, C, unified RAM and control FSM.
module acc_processor_p
    import acc_proc_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enter,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              halt,
    output logic              carry,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] acc,
    output logic [2:0]        state,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                c_q, c_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                ov_q, ov_d;
    logic                enter_q;
    logic                sta_we;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [OPC_W-1:0]    opc;
    logic [ADDR_W-1:0]   opa;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   mem_rd;
    logic                enter_rise;
    logic                a_zero;
    logic                a_pos;
    logic [DATA_W-1:0]   alu_a;
    logic                alu_c;

    assign opc        = ir_q[DATA_W-1 -: OPC_W];
    assign opa        = ir_q[ADDR_W-1:0];
    assign rd_addr    = (state_q == S_FETCH) ? pc_q : opa;
    assign mem_rd     = mem[rd_addr];
    assign enter_rise = enter & ~enter_q;
    assign a_zero     = (acc_q == '0);
    assign a_pos      = !a_zero && !acc_q[DATA_W-1];

    acc_proc_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (opc),
        .a      (acc_q),
        .m      (mem_rd),
        .c      (c_q),
        .a_next (alu_a),
        .c_next (alu_c)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        c_d     = c_q;
        out_d   = out_q;
        ov_d    = 1'b0;
        sta_we  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_d    = mem_rd;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                acc_d   = alu_a;
                c_d     = alu_c;
                case (opc)
                    OP_STA:  sta_we = 1'b1;
                    OP_IN:   state_d = S_IN_WAIT;
                    OP_OUT: begin
                        out_d = acc_q;
                        ov_d  = 1'b1;
                    end
                    OP_JZ:   if (a_zero) pc_d = opa;
                    OP_JPOS: if (a_pos) pc_d = opa;
                    OP_JMP:  pc_d = opa;
                    OP_JC:   if (c_q) pc_d = opa;
                    OP_HALT: state_d = S_HALT;
                    default: ;
                endcase
            end
            S_IN_WAIT: begin
                if (enter_rise) begin
                    acc_d   = in;
                    state_d = S_FETCH;
                end
            end
            S_HALT: if (enter_rise) state_d = S_FETCH;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HALT;
            pc_q    <= '0;
            ir_q    <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            out_q   <= '0;
            ov_q    <= 1'b0;
            enter_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
            enter_q <= enter;
        end
    end

    // RAM contents survive reset; a reset in the STA cycle drops the write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (sta_we) begin
                mem[opa] <= acc_q;
            end else if (state_q == S_HALT && prog_we) begin
                mem[prog_addr] <= prog_data;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = ov_q;
    assign halt      = (state_q == S_HALT);
    assign carry     = c_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign acc       = acc_q;
    assign state     = state_q;

endmodule

// File: tb/tb_acc_processor_p.sv
// Scoreboard bench for acc_processor_p: directed programs, OUT values checked by a monitor.
module tb_acc_processor_p;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enter = 1'b0;
    logic [7:0] in = 8'h00;
    logic [7:0] out;
    logic       out_valid;
    logic       halt;
    logic       carry;
    logic [3:0] pc;
    logic [7:0] ir;
    logic [7:0] acc;
    logic [2:0] state;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = 4'h0;
    logic [7:0] prog_data = 8'h00;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    acc_processor_p #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .enter     (enter),
        .in        (in),
        .out       (out),
        .out_valid (out_valid),
        .halt      (halt),
        .carry     (carry),
        .pc        (pc),
        .ir        (ir),
        .acc       (acc),
        .state     (state),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every out_valid strobe must match the next queued value.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("out_unexpected", {24'h0, out}, 32'hFFFF_FFFF);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("out_value", {24'h0, out}, {24'h0, e});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        tick(n);
        reset = 1'b0;
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        prog_addr = a;
        prog_data = d;
        prog_we   = 1'b1;
        tick(1);
        prog_we   = 1'b0;
    endtask

    task automatic start();
        enter = 1'b1;
        tick(1);
        enter = 1'b0;
    endtask

    task automatic wait_halt(output int n);
        n = 0;
        while (!halt && n < 300) begin
            tick(1);
            n++;
        end
        if (!halt) chk("halt_timeout", {31'h0, halt}, 32'h1);
    endtask

    initial begin
        int n;

        // Reset state
        do_reset(2);
        chk("rst_halt", {31'h0, halt}, 32'h1);
        chk("rst_state", {29'h0, state}, 32'h4);
        chk("rst_pc", {28'h0, pc}, 32'h0);
        chk("rst_acc", {24'h0, acc}, 32'h0);
        chk("rst_carry", {31'h0, carry}, 32'h0);
        chk("rst_out", {24'h0, out}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);

        // Add, out, halt: 5 + 7 = 0x0C, four instructions take 12 cycles
        load(4'd0, 8'h0E); load(4'd1, 8'h2F); load(4'd2, 8'h50); load(4'd3, 8'hF0);
        load(4'd14, 8'h05); load(4'd15, 8'h07);
        exp_q.push_back(8'h0C);
        start();
        chk("add_left_halt", {31'h0, halt}, 32'h0);
        wait_halt(n);
        chk("add_cycles", n, 12);
        chk("add_pc", {28'h0, pc}, 32'h4);
        chk("add_out_valid_low", {31'h0, out_valid}, 32'h0);

        // Carry out of ADD, JC taken, then SHR into carry
        do_reset(1);
        load(4'd14, 8'hFF); load(4'd15, 8'h02);
        load(4'd0, 8'h0E); load(4'd1, 8'h2F); load(4'd2, 8'hD6); load(4'd3, 8'hF0);
        load(4'd6, 8'h50); load(4'd7, 8'hF0);
        exp_q.push_back(8'h01);
        start();
        wait_halt(n);
        chk("jc_acc", {24'h0, acc}, 32'h01);
        chk("jc_carry", {31'h0, carry}, 32'h1);
        chk("jc_pc", {28'h0, pc}, 32'h8);
        load(4'd8, 8'hC0); load(4'd9, 8'hF0);
        start();
        wait_halt(n);
        chk("shr_acc", {24'h0, acc}, 32'h00);
        chk("shr_carry", {31'h0, carry}, 32'h1);
        chk("shr_pc", {28'h0, pc}, 32'hA);

        // IN handshake: wait in IN_WAIT, rise loads A, held enter does not retrigger
        do_reset(1);
        load(4'd0, 8'h40); load(4'd1, 8'h50); load(4'd2, 8'hF0);
        in = 8'h3C;
        start();
        tick(10);
        chk("in_wait_state", {29'h0, state}, 32'h3);
        chk("in_wait_pc", {28'h0, pc}, 32'h1);
        chk("in_wait_ov", {31'h0, out_valid}, 32'h0);
        exp_q.push_back(8'h3C);
        enter = 1'b1;
        tick(1);
        chk("in_acc", {24'h0, acc}, 32'h3C);
        wait_halt(n);
        tick(5);
        chk("in_no_retrigger", {31'h0, halt}, 32'h1);
        chk("in_pc", {28'h0, pc}, 32'h3);
        enter = 1'b0;
        tick(1);

        // Countdown loop 3 -> 2,1,0 then fall through; then SUB borrow
        do_reset(1);
        load(4'd0, 8'h0D); load(4'd1, 8'h3C); load(4'd2, 8'h50); load(4'd3, 8'h71);
        load(4'd4, 8'hF0); load(4'd12, 8'h01); load(4'd13, 8'h03);
        exp_q.push_back(8'h02); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
        start();
        wait_halt(n);
        chk("loop_acc", {24'h0, acc}, 32'h00);
        chk("loop_pc", {28'h0, pc}, 32'h5);
        chk("loop_carry", {31'h0, carry}, 32'h0);
        load(4'd5, 8'h3C); load(4'd6, 8'hF0);
        start();
        wait_halt(n);
        chk("borrow_acc", {24'h0, acc}, 32'hFF);
        chk("borrow_carry", {31'h0, carry}, 32'h1);

        // PC wrap: JMP 14, NOP, NOP -> PC wraps to 0
        do_reset(1);
        load(4'd0, 8'h8E); load(4'd14, 8'hE0); load(4'd15, 8'hE0);
        start();
        tick(7);
        chk("wrap_pc", {28'h0, pc}, 32'h0);
        chk("wrap_state", {29'h0, state}, 32'h1);
        chk("wrap_ir", {24'h0, ir}, 32'hE0);

        // Reset during IN_WAIT
        do_reset(1);
        load(4'd0, 8'h40); load(4'd1, 8'hF0);
        start();
        tick(6);
        chk("rin_state_pre", {29'h0, state}, 32'h3);
        do_reset(1);
        chk("rin_state", {29'h0, state}, 32'h4);
        chk("rin_pc", {28'h0, pc}, 32'h0);

        // Reset during EXEC of STA suppresses the write
        load(4'd10, 8'h77); load(4'd0, 8'h1A); load(4'd1, 8'hF0);
        start();
        tick(2);
        chk("sta_exec_state", {29'h0, state}, 32'h2);
        do_reset(1);
        load(4'd0, 8'h0A); load(4'd1, 8'h50); load(4'd2, 8'hF0);
        exp_q.push_back(8'h77);
        start();
        wait_halt(n);

        // Loader ignored while running, honoured in HALT
        do_reset(1);
        load(4'd0, 8'h40); load(4'd1, 8'h0A); load(4'd2, 8'h50); load(4'd3, 8'hF0);
        load(4'd10, 8'h55);
        in = 8'h00;
        start();
        tick(5);
        load(4'd10, 8'hAA);
        exp_q.push_back(8'h55);
        start();
        wait_halt(n);
        load(4'd10, 8'hAA); load(4'd4, 8'h0A); load(4'd5, 8'h50); load(4'd6, 8'hF0);
        exp_q.push_back(8'hAA);
        start();
        wait_halt(n);
        chk("ld_pc", {28'h0, pc}, 32'h7);

        tick(2);
        chk("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
